ram_char_dp: RTL and testbench

- Single-clock character/text buffer RAM with a synchronous write port and a registered read port.
- Parametrised width, depth, read latency and read-during-write mode.
- Built-in clear sequencer sweeps the whole array to a fill value.
- Sits between the text writer (CPU/UART bridge) and the character-generator read path of the display pipeline.

---
 rtl/ram_char_pkg.sv | 10 +
 rtl/ram_char_clr_seq.sv | 69 ++++++
 rtl/ram_char_dp.sv | 93 +++++++++
 tb/tb_ram_char_dp.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_char_pkg.sv
// Shared constants and clear-sequencer state encoding for the character buffer RAM.
package ram_char_pkg;
   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_e;
endpackage

// File: rtl/ram_char_clr_seq.sv
// Clear sweep sequencer: owns the RAM write port, muxing user writes with the fill sweep.
module ram_char_clr_seq
   import ram_char_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    ADDR_WIDTH  = 8,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  clr_busy,
   output logic                  clr_done,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_waddr,
   output logic [DATA_WIDTH-1:0] mem_wdata
);
   localparam logic [ADDR_WIDTH-1:0] LAST = '1;

   clr_state_e            state, state_nx;
   logic [ADDR_WIDTH-1:0] cnt, cnt_nx;
   logic                  done_nx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         clr_done <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         clr_done <= done_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      done_nx   = 1'b0;
      mem_we    = we;
      mem_waddr = waddr;
      mem_wdata = wdata;
      case (state)
         ST_IDLE: begin
            if (clr) begin
               state_nx = ST_CLEAR;
               cnt_nx   = '0;
            end
         end
         ST_CLEAR: begin
            // sweep owns the port; user writes and clr re-pulses are dropped
            mem_we    = 1'b1;
            mem_waddr = cnt;
            mem_wdata = CLEAR_VALUE;
            cnt_nx    = cnt + 1'b1;
            if (cnt == LAST) begin
               state_nx = ST_IDLE;
               done_nx  = 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign clr_busy = (state == ST_CLEAR);
endmodule

// File: rtl/ram_char_dp.sv
// Character buffer RAM: one write port (shared with clear sweep), registered read port.
module ram_char_dp
   import ram_char_pkg::*;
#(
   parameter int                    DATA_WIDTH    = 8,
   parameter int                    ADDR_WIDTH    = 8,
   parameter string                 RAM_INIT_FILE = "",
   parameter int                    OUT_REG       = 0,
   parameter int                    RDW_MODE      = 0,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rvalid,
   input  logic                  clr,
   output logic                  clr_busy,
   output logic                  clr_done
);
   localparam int DEPTH  = 2 ** ADDR_WIDTH;
   localparam int STAGES = (OUT_REG != 0) ? 1 : 0;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] rd_q;
   logic [STAGES:0]       vld_pipe;
   logic                  rdw_hit;

   ram_char_clr_seq #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .CLEAR_VALUE(CLEAR_VALUE)
   ) u_clr_seq (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .clr_busy (clr_busy),
      .clr_done (clr_done),
      .mem_we   (mem_we),
      .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata)
   );

   // array has no reset: contents survive rst
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   assign rdw_hit = (RDW_MODE == RDW_NEW) && mem_we && (mem_waddr == raddr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q <= '0;
      end else if (re) begin
         rd_q <= rdw_hit ? mem_wdata : mem[raddr];
      end
   end

   // vld_pipe[0] marks rd_q freshly loaded; vld_pipe[STAGES] is the output strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= re;
         for (int i = 1; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [DATA_WIDTH-1:0] oreg;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)              oreg <= '0;
            else if (vld_pipe[0]) oreg <= rd_q;
         end
         assign rdata = oreg;
      end else begin : g_noreg
         assign rdata = rd_q;
      end
   endgenerate

   assign rvalid = vld_pipe[STAGES];
endmodule

// File: tb/tb_ram_char_dp.sv
// Bench for ram_char_dp: instance a (latency 1, old-data RDW), instance b (latency 2, write-through).
module tb_ram_char_dp;
   typedef struct {
      logic [7:0] data;
      int         due;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       we = 1'b0, re = 1'b0, clr = 1'b0;
   logic [3:0] waddr = '0, raddr = '0;
   logic [7:0] wdata = '0;
   logic [7:0] rdata_a, rdata_b;
   logic       rvalid_a, rvalid_b, busy_a, busy_b, done_a, done_b;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;
   exp_t qa[$];
   exp_t qb[$];
   logic [7:0] model [16];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   ram_char_dp #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RAM_INIT_FILE(""), .OUT_REG(0),
                 .RDW_MODE(0), .CLEAR_VALUE(8'h20)) dut_a (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
      .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a), .clr(clr),
      .clr_busy(busy_a), .clr_done(done_a));

   ram_char_dp #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RAM_INIT_FILE(""), .OUT_REG(1),
                 .RDW_MODE(1), .CLEAR_VALUE(8'h20)) dut_b (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
      .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b), .clr(clr),
      .clr_busy(busy_b), .clr_done(done_b));

   // scoreboard: each expected read has a data value and the cycle it must appear in
   always @(negedge clk) begin
      if (mon_en) begin
         exp_t e;
         checks++;
         if (qa.size() > 0 && qa[0].due == cyc) begin
            e = qa.pop_front();
            if (rvalid_a !== 1'b1 || rdata_a !== e.data) begin
               failures++;
               $display("FAIL rd_a cyc=%0d got rvalid=%b rdata=%h want rvalid=1 rdata=%h",
                        cyc, rvalid_a, rdata_a, e.data);
            end
         end else if (rvalid_a !== 1'b0) begin
            failures++;
            $display("FAIL rvalid_a cyc=%0d got %b want 0", cyc, rvalid_a);
         end
         checks++;
         if (qb.size() > 0 && qb[0].due == cyc) begin
            e = qb.pop_front();
            if (rvalid_b !== 1'b1 || rdata_b !== e.data) begin
               failures++;
               $display("FAIL rd_b cyc=%0d got rvalid=%b rdata=%h want rvalid=1 rdata=%h",
                        cyc, rvalid_b, rdata_b, e.data);
            end
         end else if (rvalid_b !== 1'b0) begin
            failures++;
            $display("FAIL rvalid_b cyc=%0d got %b want 0", cyc, rvalid_b);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      we = 1'b0; re = 1'b0; clr = 1'b0;
      repeat (n) step();
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      we = 1'b1; waddr = a; wdata = d; model[a] = d;
      step();
      we = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a);
      re = 1'b1; raddr = a;
      qa.push_back('{model[a], cyc + 1});
      qb.push_back('{model[a], cyc + 2});
   endtask

   task automatic drain(input string name);
      idle(4);
      checks++;
      if (qa.size() != 0 || qb.size() != 0) begin
         failures++;
         $display("FAIL %s_drain got pending a=%0d b=%0d want 0 0", name, qa.size(), qb.size());
         qa.delete(); qb.delete();
      end
   endtask

   task automatic test_reset();
      repeat (3) step();
      @(negedge clk);
      checks++;
      if ({rdata_a, rdata_b} !== 16'h0 || {rvalid_a, rvalid_b, busy_a, busy_b, done_a, done_b} !== 6'b0) begin
         failures++;
         $display("FAIL reset got rdata=%h/%h rv=%b/%b busy=%b/%b done=%b/%b want all 0",
                  rdata_a, rdata_b, rvalid_a, rvalid_b, busy_a, busy_b, done_a, done_b);
      end
      rst = 1'b0;
      step();
      mon_en = 1'b1;
   endtask

   task automatic test_write_read();
      wr(4'd3, 8'h41);
      rd(4'd3);
      step();
      drain("write_read");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) wr(4'(i), 8'h10 + 8'(i));
      for (int i = 0; i < 4; i++) begin
         rd(4'(i));
         step();
      end
      drain("back_to_back");
   endtask

   task automatic test_rdw();
      wr(4'd5, 8'h22);
      we = 1'b1; waddr = 4'd5; wdata = 8'h55;
      re = 1'b1; raddr = 4'd5;
      qa.push_back('{8'h22, cyc + 1});
      qb.push_back('{8'h55, cyc + 2});
      model[5] = 8'h55;
      step();
      we = 1'b0;
      rd(4'd5);
      step();
      drain("rdw");
   endtask

   task automatic test_clear();
      int nbusy = 0, ndone = 0;
      clr = 1'b1;
      step();
      clr = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         checks++;
         if (busy_a !== (n < 16) || busy_b !== (n < 16) || done_a !== (n == 16) || done_b !== (n == 16)) begin
            failures++;
            $display("FAIL clear_seq n=%0d got busy=%b/%b done=%b/%b want busy=%b done=%b",
                     n, busy_a, busy_b, done_a, done_b, n < 16, n == 16);
         end
         if (busy_a === 1'b1) nbusy++;
         if (done_a === 1'b1) ndone++;
         we = (n == 4); waddr = 4'd7; wdata = 8'h99;
         clr = (n == 8);
      end
      we = 1'b0; clr = 1'b0;
      checks++;
      if (nbusy != 16 || ndone != 1) begin
         failures++;
         $display("FAIL clear_len got busy=%0d done=%0d want busy=16 done=1", nbusy, ndone);
      end
      step();
      for (int i = 0; i < 16; i++) model[i] = 8'h20;
      for (int i = 0; i < 16; i++) begin
         rd(4'(i));
         step();
      end
      drain("clear");
   endtask

   task automatic test_rst_mid_sweep();
      for (int i = 0; i < 5; i++) wr(4'(i), 8'h33);
      wr(4'd15, 8'h7E);
      mon_en = 1'b0;
      clr = 1'b1;
      step();
      clr = 1'b0;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         checks++;
         if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
            failures++;
            $display("FAIL abort_busy n=%0d got %b/%b want 1", n, busy_a, busy_b);
         end
         if (n == 4) begin re = 1'b1; raddr = 4'd0; end
      end
      @(negedge clk);
      rst = 1'b1;
      re = 1'b0;
      #1;
      checks++;
      if ({busy_a, busy_b, done_a, done_b, rvalid_a, rvalid_b} !== 6'b0 || {rdata_a, rdata_b} !== 16'h0) begin
         failures++;
         $display("FAIL abort_rst got busy=%b/%b done=%b/%b rv=%b/%b rdata=%h/%h want all 0",
                  busy_a, busy_b, done_a, done_b, rvalid_a, rvalid_b, rdata_a, rdata_b);
      end
      repeat (2) begin
         @(negedge clk);
         checks++;
         if ({busy_a, busy_b, done_a, done_b} !== 4'b0) begin
            failures++;
            $display("FAIL abort_hold got busy=%b/%b done=%b/%b want 0", busy_a, busy_b, done_a, done_b);
         end
      end
      rst = 1'b0;
      step();
      qa.delete(); qb.delete();
      mon_en = 1'b1;
      for (int i = 0; i < 15; i++) model[i] = 8'h20;
      model[15] = 8'h7E;
      for (int i = 0; i < 16; i++) begin
         rd(4'(i));
         step();
      end
      drain("rst_mid_sweep");
      @(negedge clk);
      checks++;
      if (done_a !== 1'b0 || busy_a !== 1'b0) begin
         failures++;
         $display("FAIL abort_after got busy=%b done=%b want 0 0", busy_a, done_a);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_rdw();
      test_clear();
      test_rst_mid_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule
